// File: rtl/dac_spi_pkg.sv
// Frame format shared by both ends of the DAC SPI link.
// Holds the default frame length, the bit positions of the command, address
// and data fields, the command codes the receiver acts on, and the receiver
// state encoding.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEF = 32;

  // Field positions inside a frame, counted MSB first from bit 31
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 4;

  localparam int NUM_CH = 4;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] ADDR_ALL         = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } rx_state_t;

endpackage

// File: rtl/spi_dac_receiver_if.sv
// SPI bus between the DAC link master and the DAC receiver.
//   spi_sck  : serial clock, mode 0
//   spi_mosi : serial data, MSB first
//   dac_cs   : chip select, active low
//   dac_clr  : clear of all channel registers, active low
// The master modport drives the bus; the slave modport is used by the receiver.
interface spi_dac_receiver_if;
  logic spi_sck;
  logic spi_mosi;
  logic dac_cs;
  logic dac_clr;

  modport master (output spi_sck, spi_mosi, dac_cs, dac_clr);
  modport slave  (input  spi_sck, spi_mosi, dac_cs, dac_clr);
endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer with rising/falling edge detection on the
// synchronized value. SYNC_STAGES must be at least 2.
// Ports:
//   clk, rst : system clock, asynchronous active-low reset
//   din      : asynchronous input
//   q        : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// RESET_VAL sets the idle level the chain powers up to, so that leaving
// reset never produces a spurious edge.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: every clocked register uses <= so all flops update from the values
  // seen before the edge; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule

// File: rtl/spi_dac_receiver.sv
// SPI slave receiver modelling the DAC end of the link. The SPI inputs are
// oversampled on clk, 32-bit command frames are deframed, and four channel
// registers are kept up to date.
// Ports:
//   clk, rst    : system clock, asynchronous active-low reset
//   bus         : SPI bus (slave modport): spi_sck, spi_mosi, dac_cs, dac_clr
//   frame_valid : one-cycle pulse when a complete frame is accepted
//   cmd/addr/data : fields of the last accepted frame
//   ch_values   : channel registers, ch0 in the low DATA_W bits
//   frame_err   : one-cycle pulse on a bad-length frame
// Build option: define SPI_RX_FRAME_CHECK_EN to generate frame_err; without
// it frame_err is tied to 0.
// SCK high and low phases must each last at least SYNC_STAGES+1 clk periods.
module spi_dac_receiver
  import dac_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int DATA_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_dac_receiver_if.slave     bus,
  output logic                  frame_valid,
  output logic [3:0]            cmd,
  output logic [3:0]            addr,
  output logic [DATA_W-1:0]     data,
  output logic [4*DATA_W-1:0]   ch_values,
  output logic                  frame_err
);

  // Only frame bits [CMD_MSB:DATA_LSB] are stored. Bits above shift out of
  // the register, and the trailing don't-care bits are never shifted in.
  localparam int FLD_W     = CMD_MSB - DATA_LSB + 1;
  localparam int FLD_BITS  = FRAME_BITS - DATA_LSB;
  localparam int CNT_W     = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FLD  = CNT_W'(FLD_BITS);

  // Synchronized inputs and edges
  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic clr_n_s, clr_rise, clr_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(bus.spi_sck),
    .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(bus.dac_cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clr_sync (
    .clk(clk), .rst(rst), .din(bus.dac_clr),
    .q(clr_n_s), .rise(clr_rise), .fall(clr_fall)
  );

  // mosi runs through the same number of stages as sck so that a synchronized
  // sck rising edge lines up with the data bit sampled at the pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_q <= '0;
    else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // FSM
  rx_state_t state_q, state_d;
  logic      start, shift_en, finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    if (!clr_n_s) begin
      // Clear aborts any frame; a new one needs a fresh cs falling edge.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            start   = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = sck_rise;
          if (cs_rise) state_d = DONE;
        end
        DONE: begin
          finish  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register and bit counter
  logic [FLD_W-1:0] fld_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fld_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      fld_q <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      if (cnt_q < CNT_FLD) fld_q <= {fld_q[FLD_W-2:0], mosi_s};
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
    end
  end

  logic [3:0]        cmd_f, addr_f;
  logic [DATA_W-1:0] data_f;
  logic              frame_ok;

  assign cmd_f    = fld_q[CMD_MSB-DATA_LSB : CMD_LSB-DATA_LSB];
  assign addr_f   = fld_q[ADDR_MSB-DATA_LSB : ADDR_LSB-DATA_LSB];
  assign data_f   = DATA_W'(fld_q[DATA_MSB-DATA_LSB : 0]);
  assign frame_ok = finish && (cnt_q == CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid <= 1'b0;
      cmd         <= '0;
      addr        <= '0;
      data        <= '0;
    end else begin
      frame_valid <= frame_ok;
      if (frame_ok) begin
        cmd  <= cmd_f;
        addr <= addr_f;
        data <= data_f;
      end
    end
  end

  // Channel registers
  logic [DATA_W-1:0] ch_q [NUM_CH];

  // NOTE: the channel array is only four words and its contents are visible
  // outputs, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else if (!clr_n_s) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else if (frame_ok && cmd_f == CMD_WRITE_UPDATE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_f == ADDR_ALL || addr_f == 4'(i)) ch_q[i] <= data_f;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_values[g*DATA_W +: DATA_W] = ch_q[g];
  end

`ifdef SPI_RX_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_err <= 1'b0;
    else      frame_err <= finish && (cnt_q != CNT_FULL);
  end
`else
  assign frame_err = 1'b0;
`endif

  // Level and fall edges of sck and the clear edges are not needed by the
  // decoder; fold them into a dummy so they are visibly consumed.
  logic unused_sync;
  assign unused_sync = sck_s ^ sck_fall ^ cs_s ^ clr_rise ^ clr_fall;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed bench for spi_dac_receiver with hand-computed expectations.
module tb_spi_dac_receiver;

  localparam int HALF = 4;  // SCK half-period in clk cycles

  logic        clk;
  logic        rst;
  logic        frame_valid;
  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic [47:0] ch_values;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int latency;

  spi_dac_receiver_if bus ();

  spi_dac_receiver #(.SYNC_STAGES(2), .FRAME_BITS(32), .DATA_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .frame_valid(frame_valid),
    .cmd(cmd),
    .addr(addr),
    .data(data),
    .ch_values(ch_values),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && frame_valid) valid_cnt++;
    if (rst && frame_err)   err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [39:0] word, input int msb, input int lsb);
    for (int i = msb; i >= lsb; i--) begin
      bus.spi_mosi = word[i];
      tick(HALF);
      bus.spi_sck = 1'b1;
      tick(HALF);
      bus.spi_sck = 1'b0;
    end
  endtask

  // Sends the low nbits of word, then watches `gap` cycles after cs rises and
  // records the cycle at which frame_valid is first seen (-1 if never).
  task automatic send_frame(input logic [39:0] word, input int nbits, input int gap);
    @(negedge clk);
    bus.dac_cs = 1'b0;
    tick(HALF);
    if (nbits > 0) shift_bits(word, nbits - 1, 0);
    tick(HALF);
    bus.dac_cs = 1'b1;
    latency = -1;
    for (int c = 1; c <= gap; c++) begin
      @(posedge clk);
      #1;
      if (frame_valid && latency < 0) latency = c;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.dac_cs = 1'b1;
    bus.dac_clr = 1'b1;
    tick(3);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (cmd !== 4'h0) begin errors++; $display("FAIL reset_cmd: got %h expected 0", cmd); end
    checks++; if (addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
    checks++; if (data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", data); end
    checks++; if (ch_values !== 48'h0) begin errors++; $display("FAIL reset_ch: got %h expected 0", ch_values); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    rst = 1'b1;
    tick(4);
  endtask

  task automatic test_write_ch0;
    int v0 = valid_cnt;
    send_frame(40'h000030ABC0, 32, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ch0_pulses: got %0d expected 1", valid_cnt - v0); end
    checks++; if (latency !== 4) begin errors++; $display("FAIL ch0_latency: got %0d expected 4", latency); end
    checks++; if (cmd !== 4'h3) begin errors++; $display("FAIL ch0_cmd: got %h expected 3", cmd); end
    checks++; if (addr !== 4'h0) begin errors++; $display("FAIL ch0_addr: got %h expected 0", addr); end
    checks++; if (data !== 12'hABC) begin errors++; $display("FAIL ch0_data: got %h expected abc", data); end
    checks++; if (ch_values !== 48'h000000000ABC) begin errors++; $display("FAIL ch0_ch: got %h expected 000000000abc", ch_values); end
  endtask

  task automatic test_write_all;
    int v0 = valid_cnt;
    send_frame(40'h00003F1230, 32, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL all_pulses: got %0d expected 1", valid_cnt - v0); end
    checks++; if (ch_values !== 48'h123123123123) begin errors++; $display("FAIL all_ch: got %h expected 123123123123", ch_values); end
  endtask

  task automatic test_non_write;
    int v0 = valid_cnt;
    send_frame(40'h000002FFF0, 32, 10);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL nonwr_pulses: got %0d expected 1", valid_cnt - v0); end
    checks++; if (cmd !== 4'h0) begin errors++; $display("FAIL nonwr_cmd: got %h expected 0", cmd); end
    checks++; if (addr !== 4'h2) begin errors++; $display("FAIL nonwr_addr: got %h expected 2", addr); end
    checks++; if (data !== 12'hFFF) begin errors++; $display("FAIL nonwr_data: got %h expected fff", data); end
    checks++; if (ch_values !== 48'h123123123123) begin errors++; $display("FAIL nonwr_ch: got %h expected 123123123123", ch_values); end
  endtask

  task automatic test_bad_length;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    int exp_err;
`ifdef SPI_RX_FRAME_CHECK_EN
    exp_err = 2;
`else
    exp_err = 0;
`endif
    send_frame(40'h000000ABCD, 16, 10);
    send_frame(40'h0112345678, 33, 10);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL badlen_pulses: got %0d expected 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== exp_err) begin errors++; $display("FAIL badlen_err: got %0d expected %0d", err_cnt - e0, exp_err); end
    checks++; if (cmd !== 4'h0) begin errors++; $display("FAIL badlen_cmd: got %h expected 0", cmd); end
    checks++; if (addr !== 4'h2) begin errors++; $display("FAIL badlen_addr: got %h expected 2", addr); end
    checks++; if (data !== 12'hFFF) begin errors++; $display("FAIL badlen_data: got %h expected fff", data); end
    checks++; if (ch_values !== 48'h123123123123) begin errors++; $display("FAIL badlen_ch: got %h expected 123123123123", ch_values); end
  endtask

  task automatic test_zero_sck;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    int exp_err;
`ifdef SPI_RX_FRAME_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    send_frame(40'h0, 0, 10);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== exp_err) begin errors++; $display("FAIL zero_err: got %0d expected %0d", err_cnt - e0, exp_err); end
  endtask

  task automatic test_clear;
    int v0;
    int e0;
    send_frame(40'h0000315550, 32, 10);
    checks++; if (ch_values !== 48'h123123555123) begin errors++; $display("FAIL clr_pre_ch: got %h expected 123123555123", ch_values); end
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.dac_cs = 1'b0;
    tick(HALF);
    shift_bits(40'h0000317770, 31, 22);
    bus.dac_clr = 1'b0;
    tick(10);
    checks++; if (ch_values !== 48'h0) begin errors++; $display("FAIL clr_held_ch: got %h expected 0", ch_values); end
    bus.dac_clr = 1'b1;
    tick(4);
    shift_bits(40'h0000317770, 21, 0);
    tick(HALF);
    bus.dac_cs = 1'b1;
    tick(10);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL clr_abort_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL clr_abort_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (ch_values !== 48'h0) begin errors++; $display("FAIL clr_after_ch: got %h expected 0", ch_values); end
    send_frame(40'h0000310010, 32, 10);
    checks++; if (ch_values !== 48'h000000001000) begin errors++; $display("FAIL clr_next_ch: got %h expected 000000001000", ch_values); end
  endtask

  task automatic test_reset_mid_frame;
    // Put distinctive values on cmd/addr/data first so the reset is visible.
    send_frame(40'h00003F0770, 32, 10);
    @(negedge clk);
    bus.dac_cs = 1'b0;
    tick(HALF);
    shift_bits(40'h0000321110, 31, 12);
    rst = 1'b0;
    #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", frame_valid); end
    checks++; if (cmd !== 4'h0) begin errors++; $display("FAIL rstmid_cmd: got %h expected 0", cmd); end
    checks++; if (addr !== 4'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", addr); end
    checks++; if (data !== 12'h000) begin errors++; $display("FAIL rstmid_data: got %h expected 000", data); end
    checks++; if (ch_values !== 48'h0) begin errors++; $display("FAIL rstmid_ch: got %h expected 0", ch_values); end
    bus.dac_cs = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    send_frame(40'h000032ABC0, 32, 10);
    checks++; if (cmd !== 4'h3) begin errors++; $display("FAIL rstnext_cmd: got %h expected 3", cmd); end
    checks++; if (addr !== 4'h2) begin errors++; $display("FAIL rstnext_addr: got %h expected 2", addr); end
    checks++; if (data !== 12'hABC) begin errors++; $display("FAIL rstnext_data: got %h expected abc", data); end
    checks++; if (ch_values !== 48'h000ABC000000) begin errors++; $display("FAIL rstnext_ch: got %h expected 000abc000000", ch_values); end
  endtask

  task automatic test_back_to_back;
    int v0 = valid_cnt;
    // cs high for exactly SYNC_STAGES+2 = 4 cycles between the two frames.
    send_frame(40'h0000301110, 32, 4);
    send_frame(40'h0000312220, 32, 10);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", valid_cnt - v0); end
    checks++; if (ch_values !== 48'h000ABC222111) begin errors++; $display("FAIL b2b_ch: got %h expected 000abc222111", ch_values); end
  endtask

  initial begin
    test_reset;
    test_write_ch0;
    test_write_all;
    test_non_write;
    test_bad_length;
    test_zero_sck;
    test_clear;
    test_reset_mid_frame;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_dac_receiver.md
Name: spi_dac_receiver

Overview:
- SPI slave receiver modelling the DAC end of the link driven by `generator`.
- Oversamples `spi_sck`, `spi_mosi`, `dac_cs` and `dac_clr` on the system clock.
- Deframes 32-bit DAC command words and keeps the four channel output values.
- Used in benches as a self-checking DAC model; synthesizable for loopback tests on the board.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on each SPI input, minimum 2.
- FRAME_BITS, 32: bits per valid frame.
- DATA_W, 12: DAC data field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock from master; mode 0, sampled on rising edge.
- spi_mosi  in  1  serial data, MSB first.
- dac_cs  in  1  chip select, active low, frames a command.
- dac_clr  in  1  active-low clear of all channel registers.
- frame_valid  out  1  one-cycle pulse when a complete frame is accepted.
- cmd  out  4  command field of the last accepted frame.
- addr  out  4  address field of the last accepted frame.
- data  out  DATA_W  data field of the last accepted frame.
- ch_values  out  4*DATA_W  channel registers; ch0 in bits [11:0], ch3 in the top bits.
- frame_err  out  1  one-cycle pulse on a bad-length frame; tied 0 unless SPI_RX_FRAME_CHECK_EN.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, shift register 0, bit count 0, synchronizers preset to idle levels (sck=0, cs=1, clr=1).
- Frame layout, MSB first:
  - [31:24] don't-care
  - [23:20] cmd
  - [19:16] addr
  - [15:4] data
  - [3:0] don't-care
- Edge detection: performed on the synchronized signals only.
- SCK timing requirement: `spi_sck` high and low phases must each be at least SYNC_STAGES+1 clk periods. Faster SCK is unsupported and unchecked.
- FSM:
  - IDLE: a synchronized `dac_cs` falling edge clears the bit count and shift register, then goes to SHIFT.
  - SHIFT: each synchronized sck rising edge shifts in mosi and increments the bit count. The count saturates at FRAME_BITS+1. A cs rising edge goes to DONE.
  - DONE (one cycle): if count == FRAME_BITS, latch cmd, addr and data, and pulse frame_valid. Otherwise discard the frame; frame_valid stays 0. Return to IDLE.
- Latency: frame_valid rises SYNC_STAGES+2 clk cycles after the `dac_cs` rising edge at the pin. cmd, addr and data change on the same edge that frame_valid rises and hold until the next accepted frame.
- Channel update in DONE, valid frames only:
  - cmd 4'h3 (write & update), addr 0..3: ch[addr] <= data.
  - cmd 4'h3, addr 4'hF: all four channels <= data.
  - cmd 4'h3 with any other addr, and all other cmds: frame_valid still pulses; channels unchanged.
- SCK edges while cs is high are ignored.
- dac_clr (synchronized) low:
  - All channels held at 0, with priority over any same-cycle update.
  - An in-progress frame is aborted to IDLE with no valid and no err.
  - A new frame may start only after dac_clr returns high and a fresh cs falling edge is seen.
- cs rising with zero sck edges: counts as a short frame.
- Back-to-back frames: a cs high time of at least SYNC_STAGES+2 cycles is required.

Optional Feature:
- Macro: SPI_RX_FRAME_CHECK_EN.
- Defined: frame_err pulses for one cycle in DONE when count != FRAME_BITS, covering both short and over-length frames, on the same cycle a valid frame would have pulsed frame_valid.
- Undefined: frame_err is constant 0 and no comparison logic is built. All other behaviour is identical.

Decomposition:
- Package `dac_spi_pkg`:
  - FRAME_BITS default.
  - Field MSB/LSB positions.
  - Command codes CMD_WRITE_UPDATE=4'h3 and ADDR_ALL=4'hF.
  - State enum IDLE/SHIFT/DONE.
  - Shared with `generator` so both ends agree on the frame format.
- Sub-module `spi_in_sync`: parameterized SYNC_STAGES synchronizer plus rise/fall edge detect. Instantiated once per input (sck, cs, clr); mosi is synchronized only.

Test Plan:
- Frame 0x0030ABC0, SCK half-period 4 clk -> one frame_valid pulse; cmd=3, addr=0, data=0xABC; ch0=0xABC, other channels 0.
- Frame 0x003F1230 after the above -> all four channels = 0x123; frame_valid pulses exactly once.
- Frame 0x0002FFF0 (cmd 0) -> frame_valid=1, data=0xFFF, ch_values unchanged.
- 16-bit frame then 33-bit frame -> no frame_valid, outputs unchanged; frame_err pulses twice with the macro defined, stays 0 without it.
- dac_clr low for 10 cycles mid-frame after ch1=0x555 -> ch_values=0 and no pulse. A following 0x00310010 frame is accepted -> ch1=0x001.
- rst low mid-frame at bit 20 -> all outputs 0 immediately. The next full frame is decoded correctly. With `generator` DIV=3 driving the inputs, the received data matches the generator's sent samples.
